// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic pipeline stage register with a valid/ready handshake and a
//   2-entry skid buffer (main + skid). in_ready is a decode of the state
//   register only, so backpressure never ripples combinationally upstream.
//   flush drops every held and incoming beat. A saturating counter records
//   the cycles in which no beat was presented downstream.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   EMPTY | nothing held, out_valid=0, in_ready=1
//   BUSY  | main register holds one beat, out_valid=1, in_ready=1
//   FULL  | main and skid both hold a beat, out_valid=1, in_ready=0
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   flush       drop all held and incoming beats
//   in_valid    upstream beat valid
//   in_ready    stage can accept (registered, low only when FULL)
//   in_data     upstream payload, lane k at [k*DATA_W +: DATA_W]
//   out_valid   downstream beat valid (main register full)
//   out_ready   downstream accepts
//   out_data    main register payload
//   occupancy   held beats: 0, 1 or 2
//   clear_cnt   synchronous clear of bubble_cnt
//   bubble_cnt  saturating count of cycles with out_valid=0

module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int LANES  = 5,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_W-1:0]   out_data,
   output logic [1:0]                occupancy,
   input  logic                      clear_cnt,
   output logic [CNT_W-1:0]          bubble_cnt
);

   localparam int PW = LANES * DATA_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   main_data;
   logic [PW-1:0]   skid_data;
   logic            in_fire;
   logic            out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic; flush wins over any handshake
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_fire) state_nxt = BUSY;
            BUSY: begin
               if (in_fire && !out_fire)      state_nxt = FULL;
               else if (!in_fire && out_fire) state_nxt = EMPTY;
            end
            FULL:    if (out_fire) state_nxt = BUSY;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // outputs decode the state register only, so they are glitch-free and
   // never depend on out_ready within the same cycle
   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b1;
      occupancy = 2'd0;
      case (state)
         BUSY: begin
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         FULL: begin
            out_valid = 1'b1;
            in_ready  = 1'b0;
            occupancy = 2'd2;
         end
         default: ;
      endcase
   end

   // payload registers; a beat arriving during flush is discarded
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         main_data <= '0;
         skid_data <= '0;
      end else begin
         case (state)
            EMPTY: if (in_fire) main_data <= in_data;
            BUSY: begin
               if (in_fire && out_fire) main_data <= in_data;
               else if (in_fire)        skid_data <= in_data;
            end
            FULL:    if (out_fire) main_data <= skid_data;
            default: ;
         endcase
      end
   end

   assign out_data = main_data;

   always_ff @(posedge clk) begin
      if (rst || clear_cnt) begin
         bubble_cnt <= '0;
      end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios followed by a long random
// run, all checked against a queue-based model of the stage.

module tb_pipe_stage_skid;

   localparam int DW      = 32;
   localparam int NL      = 5;
   localparam int CW      = 4;
   localparam int PW      = DW * NL;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic            clk;
   logic            rst;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [PW-1:0]   in_data;
   logic            out_valid;
   logic            out_ready;
   logic [PW-1:0]   out_data;
   logic [1:0]      occupancy;
   logic            clear_cnt;
   logic [CW-1:0]   bubble_cnt;

   pipe_stage_skid #(.DATA_W(DW), .LANES(NL), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .occupancy  (occupancy),
      .clear_cnt  (clear_cnt),
      .bubble_cnt (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // model: beats held by the stage, oldest first, plus visible payload
   logic [PW-1:0] q[$];
   logic [PW-1:0] m_last;
   int            m_cnt;
   int            dut_fires;

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [PW-1:0] mk(input logic [DW-1:0] lane0, input bit rnd);
      logic [PW-1:0] d;
      d = '0;
      d[DW-1:0] = lane0;
      for (int k = 1; k < NL; k++)
         d[k*DW +: DW] = rnd ? DW'($urandom) : (lane0 ^ (DW'(k) << 28));
      return d;
   endfunction

   // one clock: drive at negedge, update model at posedge, compare at next negedge
   task automatic cycle(input logic r, input logic f, input logic iv,
                        input logic [PW-1:0] d, input logic ordy, input logic clr);
      bit ov;
      bit ir;
      rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy; clear_cnt = clr;
      ov = (q.size() > 0);
      ir = (q.size() < 2);
      @(posedge clk);
      if (!r && ov && ordy) dut_fires++;
      if (r) begin
         q.delete();
         m_last = '0;
         m_cnt  = 0;
      end else begin
         if (clr)                        m_cnt = 0;
         else if (!ov && m_cnt < CNT_MAX) m_cnt++;
         if (f) begin
            q.delete();
            m_last = '0;
         end else begin
            if (ov && ordy) void'(q.pop_front());
            if (iv && ir)   q.push_back(d);
            if (q.size() > 0) m_last = q[0];
         end
      end
      @(negedge clk);
      chk("out_valid",  PW'(out_valid),  PW'(q.size() > 0));
      chk("in_ready",   PW'(in_ready),   PW'(q.size() < 2));
      chk("occupancy",  PW'(occupancy),  PW'(q.size()));
      chk("out_data",   out_data,        m_last);
      chk("bubble_cnt", PW'(bubble_cnt), PW'(m_cnt));
      chk("rdy_vs_occ", PW'(in_ready),   PW'(occupancy < 2'd2));
   endtask

   logic [PW-1:0] zero_d;

   initial begin
      zero_d    = '0;
      m_last    = '0;
      m_cnt     = 0;
      dut_fires = 0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; clear_cnt = 1'b0;
      @(negedge clk);

      // reset with random inputs
      for (int i = 0; i < 2; i++)
         cycle(1'b1, 1'($urandom), 1'($urandom), mk(DW'($urandom), 1'b1), 1'($urandom), 1'($urandom));
      chk("rst_out_valid", PW'(out_valid), '0);
      chk("rst_in_ready",  PW'(in_ready),  PW'(1));
      chk("rst_out_data",  out_data,       '0);
      chk("rst_occ",       PW'(occupancy), '0);
      chk("rst_bubble",    PW'(bubble_cnt), '0);

      // streaming at full rate
      dut_fires = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 1'b1, mk(DW'(4 * i), 1'b0), 1'b1, 1'b0);
         chk("stream_lane0", PW'(out_data[DW-1:0]), PW'(4 * i));
         chk("stream_ready", PW'(in_ready), PW'(1));
      end
      cycle(1'b0, 1'b0, 1'b0, zero_d, 1'b1, 1'b0);
      chk("stream_beats", PW'(dut_fires), PW'(10));

      // backpressure fills the skid
      cycle(1'b0, 1'b0, 1'b1, mk(32'h100, 1'b0), 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, mk(32'h104, 1'b0), 1'b0, 1'b0);
      chk("bp_occ",   PW'(occupancy), PW'(2));
      chk("bp_ready", PW'(in_ready),  PW'(0));
      chk("bp_A",     out_data,       mk(32'h100, 1'b0));
      for (int i = 0; i < 2; i++)
         cycle(1'b0, 1'b0, 1'b1, mk(32'h108, 1'b0), 1'b0, 1'b0);
      chk("bp_C_held", PW'(occupancy), PW'(2));
      chk("bp_still_A", PW'(out_data[DW-1:0]), PW'(32'h100));
      cycle(1'b0, 1'b0, 1'b1, mk(32'h108, 1'b0), 1'b1, 1'b0);
      chk("bp_B", PW'(out_data[DW-1:0]), PW'(32'h104));
      cycle(1'b0, 1'b0, 1'b1, mk(32'h108, 1'b0), 1'b1, 1'b0);
      chk("bp_C", PW'(out_data[DW-1:0]), PW'(32'h108));
      chk("bp_C_valid", PW'(out_valid), PW'(1));
      cycle(1'b0, 1'b0, 1'b0, zero_d, 1'b1, 1'b0);

      // flush while FULL drops D
      cycle(1'b0, 1'b0, 1'b1, mk(32'h180, 1'b0), 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, mk(32'h184, 1'b0), 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, mk(32'h200, 1'b0), 1'b1, 1'b0);
      chk("fl_valid", PW'(out_valid), PW'(0));
      chk("fl_occ",   PW'(occupancy), PW'(0));
      chk("fl_data",  out_data,       '0);
      cycle(1'b0, 1'b0, 1'b1, mk(32'h204, 1'b0), 1'b0, 1'b0);
      chk("fl_E", out_data, mk(32'h204, 1'b0));
      chk("fl_E_valid", PW'(out_valid), PW'(1));
      cycle(1'b0, 1'b0, 1'b0, zero_d, 1'b1, 1'b0);

      // bubble counter saturation and clear
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, zero_d, 1'b1, 1'b0);
      chk("cnt_sat", PW'(bubble_cnt), PW'(15));
      cycle(1'b0, 1'b0, 1'b0, zero_d, 1'b1, 1'b1);
      chk("cnt_clr", PW'(bubble_cnt), PW'(0));
      cycle(1'b0, 1'b0, 1'b0, zero_d, 1'b1, 1'b0);
      chk("cnt_one", PW'(bubble_cnt), PW'(1));
      cycle(1'b0, 1'b0, 1'b0, zero_d, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, zero_d, 1'b1, 1'b1);
      chk("cnt_clr_rst", PW'(bubble_cnt), PW'(0));

      // random traffic
      for (int i = 0; i < 10000; i++)
         cycle(1'b0, ($urandom_range(99) < 2), 1'($urandom), mk(DW'($urandom), 1'b1),
               1'($urandom), ($urandom_range(99) < 1));

      // reset mid-operation leaves nothing behind
      cycle(1'b0, 1'b0, 1'b1, mk(32'h300, 1'b0), 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, mk(32'h304, 1'b0), 1'b0, 1'b0);
      chk("rst_mid_valid", PW'(out_valid), PW'(0));
      chk("rst_mid_data",  out_data,       '0);
      cycle(1'b0, 1'b0, 1'b0, zero_d, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
